cacheline_xfer: RTL and testbench

Line-transfer engine that acts as the initiator on a single-port byte-enabled SRAM (`ram1p1rwbe` interface: sampled address, read data valid the cycle after the edge). It fills a whole cache line into the SRAM from a valid/ready beat stream, or evicts a whole line out of the SRAM onto a valid/ready beat stream. It sits between the cache's bus-side fill/writeback path and the cache data subarray.

---
 rtl/cacheline_xfer_pkg.sv | 12 +
 rtl/cacheline_xfer_if.sv | 28 ++
 rtl/flopenr.sv | 15 +
 rtl/ram1p1rwbe.sv | 30 +++
 rtl/cacheline_xfer.sv | 99 +++++++++
 tb/tb_cacheline_xfer.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/cacheline_xfer_pkg.sv
// Shared types for the cache line transfer engine.
package cacheline_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        EV_PRIME,
        EV_STREAM,
        DONE
    } xfer_state_t;

endpackage

// File: rtl/cacheline_xfer_if.sv
// Command, fill-beat and evict-beat handshakes between the cache bus path and the engine.
interface cacheline_xfer_if #(
    parameter int WIDTH = 128,
    parameter int LW    = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [LW-1:0]    cmd_line;
    logic             fill_valid;
    logic             fill_ready;
    logic [WIDTH-1:0] fill_data;
    logic             ev_valid;
    logic             ev_ready;
    logic [WIDTH-1:0] ev_data;
    logic             ev_last;
    logic             done;

    modport master (
        output cmd_valid, cmd_write, cmd_line, fill_valid, fill_data, ev_ready,
        input  cmd_ready, fill_ready, ev_valid, ev_data, ev_last, done
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_line, fill_valid, fill_data, ev_ready,
        output cmd_ready, fill_ready, ev_valid, ev_data, ev_last, done
    );
endinterface

// File: rtl/flopenr.sv
// Enabled flop with synchronous active-high reset.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/ram1p1rwbe.sv
// Single-port byte-enabled SRAM: address sampled on the edge, read data held until the next access.
module ram1p1rwbe #(
    parameter  int USE_SRAM = 0,
    parameter  int DEPTH    = 64,
    parameter  int WIDTH    = 128,
    localparam int AW       = $clog2(DEPTH),
    localparam int BW       = (WIDTH-1)/8+1
) (
    input  logic             clk,
    input  logic             ce,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    input  logic [BW-1:0]    bwe,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Only the array model lives in this library; a hard macro would hang off USE_SRAM.
    if (USE_SRAM == 0) begin : g_model
        always_ff @(posedge clk) begin
            if (ce) begin
                dout <= mem[addr];
                if (we)
                    for (int b = 0; b < BW; b++)
                        if (bwe[b]) mem[addr][b*8 +: 8] <= din[b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/cacheline_xfer.sv
// Fills a whole cache line into the data SRAM from a beat stream, or evicts one out onto a beat stream.
module cacheline_xfer
    import cacheline_xfer_pkg::*;
#(
    parameter  int DEPTH     = 64,
    parameter  int WIDTH     = 128,
    parameter  int LINEWORDS = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int OW        = $clog2(LINEWORDS),
    localparam int LW        = AW - OW,
    localparam int BW        = (WIDTH-1)/8+1
) (
    input  logic               clk,
    input  logic               reset,
    cacheline_xfer_if.slave    bus,
    output logic               ram_ce,
    output logic               ram_we,
    output logic [AW-1:0]      ram_addr,
    output logic [WIDTH-1:0]   ram_din,
    output logic [BW-1:0]      ram_bwe,
    input  logic [WIDTH-1:0]   ram_dout
);
    localparam logic [OW-1:0] LAST = OW'(LINEWORDS-1);

    xfer_state_t   state, state_nxt;
    logic [LW-1:0] line;
    logic [OW-1:0] k, k_inc, k_nxt;
    logic          k_en, accept, fill_hs, ev_hs, last;

    assign last    = (k == LAST);
    assign accept  = (state == IDLE) && bus.cmd_valid;
    assign fill_hs = (state == FILL) && bus.fill_valid;
    assign ev_hs   = (state == EV_STREAM) && bus.ev_ready;
    assign k_inc   = k + 1'b1;
    assign k_nxt   = accept ? '0 : k_inc;
    // The final handshake leaves k parked at LAST rather than wrapping.
    assign k_en    = accept | ((fill_hs | ev_hs) & ~last);

    flopenr #(.WIDTH(OW)) u_k    (.clk(clk), .reset(reset), .en(k_en),   .d(k_nxt),        .q(k));
    flopenr #(.WIDTH(LW)) u_line (.clk(clk), .reset(reset), .en(accept), .d(bus.cmd_line), .q(line));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (bus.cmd_valid) state_nxt = bus.cmd_write ? FILL : EV_PRIME;
            FILL:      if (fill_hs && last) state_nxt = DONE;
            EV_PRIME:  state_nxt = EV_STREAM;
            EV_STREAM: if (ev_hs && last) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Evict data is straight from the SRAM; a stall drops ram_ce so the read stays put.
    assign bus.ev_data = ram_dout;

    always_comb begin
        bus.cmd_ready  = 1'b0;
        bus.fill_ready = 1'b0;
        bus.ev_valid   = 1'b0;
        bus.ev_last    = 1'b0;
        bus.done       = 1'b0;
        ram_ce         = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = {line, k};
        ram_din        = bus.fill_data;
        ram_bwe        = '0;
        unique case (state)
            IDLE: bus.cmd_ready = 1'b1;
            FILL: begin
                bus.fill_ready = 1'b1;
                if (bus.fill_valid) begin
                    ram_ce  = 1'b1;
                    ram_we  = 1'b1;
                    ram_bwe = '1;
                end
            end
            EV_PRIME: begin
                ram_ce   = 1'b1;
                ram_addr = {line, {OW{1'b0}}};
            end
            EV_STREAM: begin
                bus.ev_valid = 1'b1;
                bus.ev_last  = last;
                if (bus.ev_ready && !last) begin
                    ram_ce   = 1'b1;
                    ram_addr = {line, k_inc};
                end
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cacheline_xfer.sv
// Directed bench for cacheline_xfer driving a behavioural ram1p1rwbe.
module tb_cacheline_xfer;
    localparam int DEPTH = 64, WIDTH = 128, LINEWORDS = 4;
    localparam int AW = 6, LW = 4, BW = 16;

    typedef logic [WIDTH-1:0] line_t [LINEWORDS];

    logic             clk = 1'b0;
    logic             reset;
    logic             ram_ce, ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_din, ram_dout;
    logic [BW-1:0]    ram_bwe;
    int               errors = 0, checks = 0;
    line_t            la, lb, ld, lpart;

    cacheline_xfer_if #(.WIDTH(WIDTH), .LW(LW)) bus ();

    cacheline_xfer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LINEWORDS(LINEWORDS)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_bwe(ram_bwe), .ram_dout(ram_dout)
    );

    ram1p1rwbe #(.USE_SRAM(0), .DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
        .clk(clk), .ce(ram_ce), .we(ram_we), .addr(ram_addr),
        .din(ram_din), .bwe(ram_bwe), .dout(ram_dout)
    );

    always #5 clk = ~clk;

    task automatic check_idle(input string tag);
        checks++;
        if (bus.cmd_ready !== 1'b1 || {bus.fill_ready, bus.ev_valid, bus.ev_last, bus.done, ram_ce, ram_we} !== 6'b0) begin
            errors++;
            $display("FAIL %s idle outputs: cmd_ready=%b fr/evv/evl/done/ce/we=%b%b%b%b%b%b expected 1 / 000000", tag,
                     bus.cmd_ready, bus.fill_ready, bus.ev_valid, bus.ev_last, bus.done, ram_ce, ram_we);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle("reset");
    endtask

    task automatic test_fill_held(input logic [LW-1:0] ln, input line_t d);
        @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_line = ln; #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL fill_accept cmd_ready=%b expected 1", bus.cmd_ready); end
        for (int b = 0; b < LINEWORDS; b++) begin
            @(negedge clk); bus.cmd_valid = 1'b0; bus.fill_valid = 1'b1; bus.fill_data = d[b]; #1;
            checks++;
            if (bus.fill_ready !== 1'b1 || ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_bwe !== '1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL fill_beat%0d fr=%b ce=%b we=%b bwe=%h done=%b expected 1 1 1 all-ones 0",
                         b, bus.fill_ready, ram_ce, ram_we, ram_bwe, bus.done);
            end
            checks++;
            if (ram_addr !== AW'(int'(ln) * LINEWORDS + b) || ram_din !== d[b]) begin
                errors++;
                $display("FAIL fill_write%0d addr=%0d din=%h expected %0d %h", b, ram_addr, ram_din,
                         int'(ln) * LINEWORDS + b, d[b]);
            end
        end
        @(negedge clk); bus.fill_valid = 1'b0; #1;
        checks++;
        if (bus.done !== 1'b1 || bus.fill_ready !== 1'b0 || ram_we !== 1'b0) begin
            errors++; $display("FAIL fill_done done=%b fr=%b we=%b expected 1 0 0", bus.done, bus.fill_ready, ram_we);
        end
        @(negedge clk); #1;
        check_idle("fill_after_done");
    endtask

    task automatic test_evict_held(input logic [LW-1:0] ln, input line_t exp);
        @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_line = ln; #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL ev_accept cmd_ready=%b expected 1", bus.cmd_ready); end
        @(negedge clk); bus.cmd_valid = 1'b0; #1;
        checks++;
        if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== AW'(int'(ln) * LINEWORDS) || bus.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL ev_prime ce=%b we=%b addr=%0d evv=%b expected 1 0 %0d 0", ram_ce, ram_we, ram_addr,
                     bus.ev_valid, int'(ln) * LINEWORDS);
        end
        for (int b = 0; b < LINEWORDS; b++) begin
            @(negedge clk); bus.ev_ready = 1'b1; #1;
            checks++;
            if (bus.ev_valid !== 1'b1 || bus.ev_data !== exp[b] || bus.ev_last !== (b == LINEWORDS-1)) begin
                errors++;
                $display("FAIL ev_beat%0d evv=%b data=%h last=%b expected 1 %h %b", b, bus.ev_valid, bus.ev_data,
                         bus.ev_last, exp[b], (b == LINEWORDS-1));
            end
            checks++;
            if (ram_ce !== (b < LINEWORDS-1) || ram_we !== 1'b0 ||
                (b < LINEWORDS-1 && ram_addr !== AW'(int'(ln) * LINEWORDS + b + 1))) begin
                errors++;
                $display("FAIL ev_read%0d ce=%b we=%b addr=%0d expected %b 0 %0d", b, ram_ce, ram_we, ram_addr,
                         (b < LINEWORDS-1), int'(ln) * LINEWORDS + b + 1);
            end
        end
        @(negedge clk); bus.ev_ready = 1'b0; #1;
        checks++;
        if (bus.done !== 1'b1 || bus.ev_valid !== 1'b0) begin
            errors++; $display("FAIL ev_done done=%b evv=%b expected 1 0", bus.done, bus.ev_valid);
        end
        @(negedge clk); #1;
        check_idle("ev_after_done");
    endtask

    task automatic test_evict_stall(input logic [LW-1:0] ln, input line_t exp);
        int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        int b = 0;
        @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_line = ln; #1;
        @(negedge clk); bus.cmd_valid = 1'b0; #1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); bus.ev_ready = pat[i][0]; #1;
            checks++;
            if (bus.ev_valid !== 1'b1 || bus.ev_data !== exp[b] || bus.ev_last !== (b == LINEWORDS-1) ||
                ram_ce !== (pat[i] == 1 && b < LINEWORDS-1)) begin
                errors++;
                $display("FAIL stall_cyc%0d evv=%b data=%h last=%b ce=%b expected 1 %h %b %b", i, bus.ev_valid,
                         bus.ev_data, bus.ev_last, ram_ce, exp[b], (b == LINEWORDS-1), (pat[i] == 1 && b < LINEWORDS-1));
            end
            if (pat[i] == 1) b++;
        end
        @(negedge clk); bus.ev_ready = 1'b0; #1;
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL stall_done done=%b expected 1", bus.done); end
        @(negedge clk); #1;
    endtask

    task automatic test_fill_gaps(input logic [LW-1:0] ln, input line_t d);
        int pat [6] = '{1, 0, 1, 0, 1, 1};
        int b = 0, wr = 0;
        @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_line = ln; #1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); bus.cmd_valid = 1'b0; bus.fill_valid = pat[i][0]; bus.fill_data = d[b]; #1;
            checks++;
            if (bus.fill_ready !== 1'b1 || ram_we !== pat[i][0] || ram_ce !== pat[i][0] ||
                (pat[i] == 1 && (ram_addr !== AW'(int'(ln) * LINEWORDS + b) || ram_din !== d[b]))) begin
                errors++;
                $display("FAIL gap_cyc%0d fr=%b we=%b ce=%b addr=%0d din=%h expected 1 %0d %0d %0d %h", i,
                         bus.fill_ready, ram_we, ram_ce, ram_addr, ram_din, pat[i], pat[i], int'(ln) * LINEWORDS + b, d[b]);
            end
            if (ram_we === 1'b1) wr++;
            if (pat[i] == 1) b++;
        end
        @(negedge clk); bus.fill_valid = 1'b0; #1;
        checks++;
        if (bus.done !== 1'b1 || wr != 4) begin
            errors++; $display("FAIL gap_done done=%b writes=%0d expected 1 4", bus.done, wr);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset_midfill();
        @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_line = '0; #1;
        @(negedge clk); bus.cmd_valid = 1'b0; bus.fill_valid = 1'b1; bus.fill_data = lpart[0]; #1;
        @(negedge clk); bus.fill_valid = 1'b0; reset = 1'b1; #1;
        @(negedge clk); reset = 1'b0; #1;
        check_idle("midfill_reset");
    endtask

    task automatic test_cmd_ignored();
        @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_line = 4'd3; #1;
        @(negedge clk); bus.cmd_line = 4'd5; #1;
        checks++;
        if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL ign_prime cmd_ready=%b expected 0", bus.cmd_ready); end
        for (int b = 0; b < LINEWORDS; b++) begin
            @(negedge clk); bus.ev_ready = 1'b1; #1;
            checks++;
            if (bus.cmd_ready !== 1'b0 || bus.ev_data !== la[b]) begin
                errors++; $display("FAIL ign_beat%0d cmd_ready=%b data=%h expected 0 %h", b, bus.cmd_ready, bus.ev_data, la[b]);
            end
        end
        @(negedge clk); bus.ev_ready = 1'b0; #1;
        checks++;
        if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL ign_done done=%b cmd_ready=%b expected 1 0", bus.done, bus.cmd_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL ign_reaccept cmd_ready=%b expected 1", bus.cmd_ready); end
        @(negedge clk); bus.cmd_valid = 1'b0; #1;
        checks++;
        if (ram_ce !== 1'b1 || ram_addr !== 6'd20) begin
            errors++; $display("FAIL ign_next_prime ce=%b addr=%0d expected 1 20", ram_ce, ram_addr);
        end
        for (int b = 0; b < LINEWORDS; b++) begin
            @(negedge clk); bus.ev_ready = 1'b1; #1;
            checks++;
            if (bus.ev_valid !== 1'b1 || bus.ev_data !== lb[b]) begin
                errors++; $display("FAIL ign_next_beat%0d evv=%b data=%h expected 1 %h", b, bus.ev_valid, bus.ev_data, lb[b]);
            end
        end
        @(negedge clk); bus.ev_ready = 1'b0; #1;
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL ign_next_done done=%b expected 1", bus.done); end
        @(negedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_line = '0;
        bus.fill_valid = 1'b0; bus.fill_data = '0; bus.ev_ready = 1'b0;
        for (int i = 0; i < LINEWORDS; i++) begin
            la[i]    = WIDTH'(128'hA0 + i);
            lb[i]    = {32'hDEAD_0000, 88'h0, 8'(8'hB0 + i)};
            ld[i]    = WIDTH'(128'hD0 + i);
            lpart[i] = WIDTH'(128'hE0 + i);
        end

        test_reset();
        test_fill_held(4'd3, la);
        test_evict_held(4'd3, la);
        test_evict_stall(4'd3, la);
        test_fill_gaps(4'd5, lb);
        test_evict_held(4'd5, lb);
        test_fill_held(4'd0, ld);
        test_reset_midfill();
        lpart[1] = ld[1]; lpart[2] = ld[2]; lpart[3] = ld[3];
        test_evict_held(4'd0, lpart);
        test_cmd_ignored();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
